// File: rtl/btn_event_port.sv
// Button event port: 2-flop sync + per-bit debounce, press events queued in a small FIFO, read/popped over the bus.
// Latency: 2 sync cycles + DEB_CYCLES sample ticks from raw press to FIFO entry; read data is combinational.
// Backpressure: a full FIFO drops new events and sets a sticky overflow flag; a same-edge pop frees the slot.
module btn_event_port #(
  parameter int DEB_CYCLES = 4,
  parameter int DEPTH      = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  btn_raw,
  input  logic        btn_en,
  input  logic [31:0] addr_bus,
  input  logic        mem_w,
  input  logic        rd_en,
  input  logic [31:0] Cpu_data2bus,
  output logic [31:0] btn_data,
  output logic [5:0]  btn_level
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int DW = $clog2(DEB_CYCLES + 1);

  // synchronizer and debounce state
  logic [5:0]          sync1_q, sync2_q;
  logic [5:0]          stable_q, stable_d;
  logic [5:0][DW-1:0]  cnt_q, cnt_d;
  logic [5:0]          ev;

  // FIFO state
  logic [5:0]          mem_q [DEPTH];
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic                ovf_q, ovf_d;

  logic sel, nonempty, full, pop, clr, push_req, push_ok;
  logic [5:0] head;

  // Address bits outside the decode and write data above bit 0 are intentionally ignored.
  logic unused_bits;
  assign unused_bits = ^{addr_bus[27:3], addr_bus[1:0], Cpu_data2bus[31:1]};

  assign sel      = (addr_bus[31:28] == 4'hD);
  assign nonempty = (count_q != '0);
  assign full     = (count_q == CW'(DEPTH));
  assign pop      = sel & rd_en & ~mem_w & ~addr_bus[2] & nonempty;
  assign clr      = sel & mem_w & addr_bus[2] & Cpu_data2bus[0];
  assign head     = mem_q[rd_ptr_q];
  assign btn_level = stable_q;

  // Per-bit debounce: count consecutive mismatching samples, flip on the DEB_CYCLES-th one.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    for (int i = 0; i < 6; i++) begin
      if (btn_en) begin
        if (sync2_q[i] != stable_q[i]) begin
          if (cnt_q[i] == DW'(DEB_CYCLES - 1)) begin
            stable_d[i] = sync2_q[i];
            cnt_d[i]    = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end else begin
          cnt_d[i] = '0;
        end
      end
    end
  end

  // Only rising debounced edges are events; releases never enqueue anything.
  assign ev       = stable_d & ~stable_q;
  assign push_req = |ev;
  // A pop on the same edge frees a slot, so a full FIFO can still accept the push.
  assign push_ok  = push_req & (~full | pop);

  // FIFO pointer/count/overflow next state; clear dominates everything, including a coincident push.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (clr) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
      if (push_ok && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push_ok) count_d = count_q - 1'b1;
      if (push_req && !push_ok) ovf_d = 1'b1;
    end
  end

  // Synchronizer, debounce and FIFO control registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      sync1_q  <= btn_raw;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // FIFO storage; contents are only observed through count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (!clr && push_ok) mem_q[wr_ptr_q] <= ev;
  end

  // Combinational read mux: STATUS at word 0, debounced level at word 1, zero when not selected.
  always_comb begin
    btn_data = '0;
    if (sel) begin
      if (addr_bus[2]) begin
        btn_data[5:0] = stable_q;
      end else begin
        btn_data[31]    = nonempty;
        btn_data[30]    = ovf_q;
        btn_data[19:16] = 4'(count_q);
        btn_data[5:0]   = nonempty ? head : 6'd0;
      end
    end
  end

endmodule

// File: tb/tb_btn_event_port.sv
// Self-checking bench for btn_event_port: vector table of press patterns plus hand-written corner sequences.
// Expected FIFO contents live in a model queue: pushed when a press is driven, popped and compared on reads.
// Every wait is a fixed cycle count; a watchdog bounds the whole run.
module tb_btn_event_port;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  btn_raw = '0;
  logic        btn_en = 1'b0;
  logic [31:0] addr_bus = 32'hD000_0000;
  logic        mem_w = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] Cpu_data2bus = '0;
  logic [31:0] btn_data;
  logic [5:0]  btn_level;

  int tests = 0;
  int fails = 0;

  logic [5:0] model_q[$];
  logic       m_ovf = 1'b0;

  typedef struct {
    logic [5:0] raw;
    int         hold;
    bit         ev;
  } vec_t;
  vec_t vecs[5];

  btn_event_port #(.DEB_CYCLES(4), .DEPTH(8)) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw), .btn_en(btn_en),
    .addr_bus(addr_bus), .mem_w(mem_w), .rd_en(rd_en),
    .Cpu_data2bus(Cpu_data2bus), .btn_data(btn_data), .btn_level(btn_level)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s = '0;
    s[31]    = (model_q.size() != 0);
    s[30]    = m_ovf;
    s[19:16] = 4'(model_q.size());
    if (model_q.size() != 0) s[5:0] = model_q[0];
    return s;
  endfunction

  task automatic model_push(input logic [5:0] code);
    if (model_q.size() < 8) model_q.push_back(code);
    else m_ovf = 1'b1;
  endtask

  task automatic model_clear();
    model_q.delete();
    m_ovf = 1'b0;
  endtask

  task automatic chk_status(input string nm);
    addr_bus = 32'hD000_0000;
    #1;
    chk(nm, btn_data, exp_status());
  endtask

  task automatic do_read(input string nm);
    logic [5:0] h;
    addr_bus = 32'hD000_0000;
    mem_w = 1'b0;
    rd_en = 1'b1;
    #1;
    chk({nm, " status"}, btn_data, exp_status());
    if (model_q.size() != 0) begin
      h = model_q.pop_front();
      chk({nm, " head"}, {26'd0, btn_data[5:0]}, {26'd0, h});
    end
    tick();
    rd_en = 1'b0;
  endtask

  task automatic write_ctrl(input logic [31:0] a, input logic [31:0] d);
    addr_bus = a;
    Cpu_data2bus = d;
    mem_w = 1'b1;
    tick();
    mem_w = 1'b0;
    Cpu_data2bus = '0;
    addr_bus = 32'hD000_0000;
  endtask

  // Full press: hold long enough to debounce, then release long enough to debounce back to 0.
  task automatic press(input logic [5:0] code);
    btn_raw = code;
    repeat (6) tick();
    model_push(code);
    btn_raw = '0;
    repeat (8) tick();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: run exceeded time limit, %0d tests run so far", tests);
    $fatal(1);
  end

  initial begin
    vecs[0] = '{6'b000100, 3, 1'b0};
    vecs[1] = '{6'b001001, 6, 1'b1};
    vecs[2] = '{6'b010000, 4, 1'b1};
    vecs[3] = '{6'b100010, 2, 1'b0};
    vecs[4] = '{6'b000110, 9, 1'b1};

    // Reset state
    repeat (3) tick();
    chk("reset status", btn_data, 32'h0);
    chk("reset level", {26'd0, btn_level}, 32'h0);
    addr_bus = 32'hD000_0004;
    #1;
    chk("reset ctrl", btn_data, 32'h0);
    addr_bus = 32'hD000_0000;
    rst = 1'b1;

    // First press latency: 2 sync + 4 samples
    btn_en = 1'b1;
    btn_raw = 6'b000001;
    repeat (5) tick();
    chk("lat edge5 status", btn_data, 32'h0);
    tick();
    model_push(6'b000001);
    chk("lat edge6 status", btn_data, 32'h8001_0001);
    addr_bus = 32'hD000_0004;
    #1;
    chk("ctrl level", btn_data, 32'h0000_0001);
    addr_bus = 32'h1000_0000;
    #1;
    chk("unselected", btn_data, 32'h0);
    do_read("read1");
    do_read("read2 empty");
    chk_status("after read2");
    btn_raw = '0;
    repeat (8) tick();

    // Vector table: glitches, simultaneous bits, exact threshold
    for (int v = 0; v < 5; v++) begin
      btn_raw = vecs[v].raw;
      repeat (vecs[v].hold) tick();
      if (vecs[v].ev) model_push(vecs[v].raw);
      btn_raw = '0;
      repeat (10) tick();
      chk_status($sformatf("vec%0d status", v));
      chk($sformatf("vec%0d level", v), {26'd0, btn_level}, 32'h0);
    end
    for (int k = 0; k < 8 && model_q.size() != 0; k++) do_read($sformatf("vec drain%0d", k));
    chk_status("vec drained");

    // Nine presses, no reads: overflow
    for (int p = 1; p <= 9; p++) press(6'(p));
    chk_status("nine presses");
    chk("nine presses const", btn_data, 32'hC008_0001);
    for (int k = 0; k < 8; k++) do_read($sformatf("ovf drain%0d", k));
    chk_status("ovf after drain");
    write_ctrl(32'hD000_0000, 32'h1);
    chk_status("status write ignored");
    write_ctrl(32'hD000_0004, 32'h0);
    chk_status("ctrl bit0=0 ignored");
    write_ctrl(32'hD000_0004, 32'h1);
    model_clear();
    chk_status("cleared");
    chk("cleared const", btn_data, 32'h0);

    // Full FIFO: push and pop on the same edge
    for (int p = 0; p < 8; p++) press(6'h10 + 6'(p));
    chk_status("full");
    btn_raw = 6'h2A;
    repeat (5) tick();
    do_read("pop with push");
    model_push(6'h2A);
    chk_status("full after push+pop");
    btn_raw = '0;
    repeat (8) tick();
    for (int k = 0; k < 8; k++) do_read($sformatf("tail drain%0d", k));
    chk_status("tail drained");

    // Clear coinciding with a push
    press(6'b000011);
    chk_status("before clear+push");
    btn_raw = 6'b110000;
    repeat (5) tick();
    write_ctrl(32'hD000_0004, 32'h1);
    model_clear();
    chk_status("clear+push");
    addr_bus = 32'hD000_0004;
    #1;
    chk("level after clear+push", btn_data, 32'h0000_0030);
    btn_raw = '0;
    repeat (8) tick();
    chk_status("clear+push release");

    // Sample tick held low
    btn_en = 1'b0;
    btn_raw = 6'b000010;
    repeat (20) tick();
    chk_status("en low status");
    chk("en low level", {26'd0, btn_level}, 32'h0);
    btn_en = 1'b1;
    repeat (3) tick();
    chk_status("en high 3 samples");
    tick();
    model_push(6'b000010);
    chk_status("en high 4 samples");
    btn_raw = '0;
    repeat (8) tick();

    // Reset mid-debounce, button still held after release
    btn_raw = 6'b000100;
    repeat (4) tick();
    rst = 1'b0;
    #1;
    model_clear();
    chk_status("mid reset status");
    chk("mid reset level", {26'd0, btn_level}, 32'h0);
    repeat (2) tick();
    rst = 1'b1;
    repeat (5) tick();
    chk_status("post reset edge5");
    tick();
    model_push(6'b000100);
    chk_status("post reset edge6");
    chk("post reset const", btn_data, 32'h8001_0004);
    btn_raw = '0;
    repeat (8) tick();
    do_read("final read");
    chk_status("final empty");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
